// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared frame constants, prefix states and key-event type
package ps2_pkg;

  localparam int START_BIT  = 0;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } key_event_t;

  // Start low, stop high, and odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] frame);
    return (frame[START_BIT] == 1'b0) && (frame[STOP_BIT] == 1'b1) &&
           (^frame[PARITY_BIT:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// rtl/ps2_scan_decoder_if.sv - frame input and key-event output bundle
interface ps2_scan_decoder_if #(
  parameter int ERR_W = 8
);
  logic [10:0]      frameData;
  logic             frameValid;
  logic [7:0]       evtCode;
  logic             evtRelease;
  logic             evtExtended;
  logic             evtValid;
  logic             evtReady;
  logic             frameError;
  logic [ERR_W-1:0] errCount;
  logic             evtOverflow;

  // Upstream frame source and downstream event consumer side.
  modport master (
    output frameData, frameValid, evtReady,
    input  evtCode, evtRelease, evtExtended, evtValid,
    input  frameError, errCount, evtOverflow
  );

  // Decoder side.
  modport slave (
    input  frameData, frameValid, evtReady,
    output evtCode, evtRelease, evtExtended, evtValid,
    output frameError, errCount, evtOverflow
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word fall-through key-event FIFO
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  key_event_t i_push_data,
  input  logic       i_pop,
  output key_event_t o_head,
  output logic       o_valid,
  output logic       o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  key_event_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;
  assign o_valid = ~w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents are don't-care until counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - frame check, E0/F0 prefix tracking, event queueing
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input logic                sysClock,
  input logic                sysReset,
  ps2_scan_decoder_if.slave  bus
);
  prefix_state_t r_state;
  prefix_state_t w_next_state;
  logic          r_frame_error;
  logic [ERR_W-1:0] r_err_count;
  logic          r_overflow;

  logic       w_good;
  logic       w_bad;
  logic [7:0] w_code;
  logic       w_emit;
  key_event_t w_event;
  key_event_t w_head;
  logic       w_drop;
  logic       w_valid;

  assign w_code = bus.frameData[8:1];
  assign w_good = bus.frameValid & frame_ok(bus.frameData);
  assign w_bad  = bus.frameValid & ~frame_ok(bus.frameData);

  // Prefix state register.
  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Prefix transitions and event generation; a bad frame clears any prefix.
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_event.code = w_code;
    w_event.rel  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    w_event.ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    if (w_bad) begin
      w_next_state = ST_IDLE;
    end else if (w_good) begin
      if (w_code == CODE_EXT) begin
        w_next_state = w_event.rel ? ST_EXT_BRK : ST_EXT;
      end else if (w_code == CODE_BRK) begin
        w_next_state = w_event.ext ? ST_EXT_BRK : ST_BRK;
      end else begin
        w_emit       = 1'b1;
        w_next_state = ST_IDLE;
      end
    end
  end

  // Error pulse, saturating error count and sticky overflow flag.
  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      r_frame_error <= 1'b0;
      r_err_count   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_error <= w_bad;
      if (w_bad && (r_err_count != '1)) r_err_count <= r_err_count + ERR_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (sysClock),
    .i_rst       (sysReset),
    .i_push      (w_emit),
    .i_push_data (w_event),
    .i_pop       (bus.evtReady),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_drop      (w_drop)
  );

  assign bus.evtCode     = w_head.code;
  assign bus.evtRelease  = w_head.rel;
  assign bus.evtExtended = w_head.ext;
  assign bus.evtValid    = w_valid;
  assign bus.frameError  = r_frame_error;
  assign bus.errCount    = r_err_count;
  assign bus.evtOverflow = r_overflow;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - directed self-checking bench for ps2_scan_decoder
module tb_ps2_scan_decoder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ps2_scan_decoder_if #(.ERR_W(8)) bus ();

  ps2_scan_decoder #(
    .FIFO_DEPTH(4),
    .ERR_W(8)
  ) dut (
    .sysClock (clk),
    .sysReset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                            input logic bad_stop, input logic bad_start);
    logic par;
    par = ~(^code) ^ bad_par;
    return {~bad_stop, par, code, bad_start};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] code, input logic bp, input logic bs, input logic bst);
    bus.frameData  = mk_frame(code, bp, bs, bst);
    bus.frameValid = 1'b1;
    @(posedge clk);
    #1;
    bus.frameValid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    bus.evtReady = 1'b1;
    @(posedge clk);
    #1;
    bus.evtReady = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] evt();
    return {22'd0, bus.evtCode, bus.evtRelease, bus.evtExtended};
  endfunction

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    bus.frameData  = '0;
    bus.frameValid = 1'b0;
    bus.evtReady   = 1'b0;
    do_reset();

    check_eq("rst_valid", bus.evtValid, 0);
    check_eq("rst_evt", evt(), 0);
    check_eq("rst_err", bus.errCount, 0);
    check_eq("rst_ferr", bus.frameError, 0);
    check_eq("rst_ovf", bus.evtOverflow, 0);

    // Plain good frame.
    send(8'h1C, 0, 0, 0);
    check_eq("plain_valid", bus.evtValid, 1);
    check_eq("plain_evt", evt(), {8'h1C, 2'b00});
    check_eq("plain_err", bus.errCount, 0);
    pop_one();
    check_eq("plain_drained", bus.evtValid, 0);

    // E0 F0 75 with consumer ready, then a plain code proves the FSM is idle.
    bus.evtReady = 1'b1;
    send(8'hE0, 0, 0, 0);
    check_eq("e0_noevt", bus.evtValid, 0);
    send(8'hF0, 0, 0, 0);
    check_eq("f0_noevt", bus.evtValid, 0);
    send(8'h75, 0, 0, 0);
    check_eq("extbrk_valid", bus.evtValid, 1);
    check_eq("extbrk_evt", evt(), {8'h75, 2'b11});
    idle();
    check_eq("extbrk_once", bus.evtValid, 0);
    send(8'hAA, 0, 0, 0);
    check_eq("after_idle_evt", evt(), {8'hAA, 2'b00});
    idle();
    bus.evtReady = 1'b0;
    check_eq("after_idle_drained", bus.evtValid, 0);

    // F0 then E0 also reaches the extended-break state.
    send(8'hF0, 0, 0, 0);
    send(8'hE0, 0, 0, 0);
    send(8'h6B, 0, 0, 0);
    check_eq("brkext_evt", evt(), {8'h6B, 2'b11});
    pop_one();

    // Rejected frames.
    send(8'h1C, 1, 0, 0);
    check_eq("badpar_ferr", bus.frameError, 1);
    check_eq("badpar_cnt", bus.errCount, 1);
    check_eq("badpar_noevt", bus.evtValid, 0);
    idle();
    check_eq("ferr_pulse", bus.frameError, 0);
    send(8'h1C, 0, 1, 0);
    check_eq("badstop_ferr", bus.frameError, 1);
    check_eq("badstop_cnt", bus.errCount, 2);
    send(8'h1C, 0, 0, 1);
    check_eq("badstart_cnt", bus.errCount, 3);
    check_eq("bad_noevt", bus.evtValid, 0);
    send(8'hE0, 0, 0, 0);
    send(8'h33, 1, 0, 0);
    check_eq("bad_clears_cnt", bus.errCount, 4);
    send(8'h1C, 0, 0, 0);
    check_eq("bad_clears_evt", evt(), {8'h1C, 2'b00});
    pop_one();

    // Overflow: five pushes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 0, 0, 0);
      if (i == 4) check_eq("ovf_before", bus.evtOverflow, 0);
    end
    check_eq("ovf_set", bus.evtOverflow, 1);
    check_eq("ovf_valid", bus.evtValid, 1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovf_order", evt(), {8'(i), 2'b00});
      pop_one();
    end
    check_eq("ovf_empty", bus.evtValid, 0);
    check_eq("ovf_sticky", bus.evtOverflow, 1);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 0, 0, 0);
    bus.evtReady = 1'b1;
    send(8'h15, 0, 0, 0);
    bus.evtReady = 1'b0;
    check_eq("pp_noovf", bus.evtOverflow, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("pp_order", evt(), {8'h12 + 8'(i), 2'b00});
      pop_one();
    end
    check_eq("pp_empty", bus.evtValid, 0);

    // Reset mid-sequence with events queued.
    send(8'h21, 0, 0, 0);
    send(8'h22, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h44, 1, 0, 0);
    rst = 1'b1;
    #1;
    check_eq("mrst_valid", bus.evtValid, 0);
    check_eq("mrst_evt", evt(), 0);
    check_eq("mrst_err", bus.errCount, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h1C, 0, 0, 0);
    check_eq("mrst_next_evt", evt(), {8'h1C, 2'b00});
    pop_one();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send(8'h1C, 1, 0, 0);
      if (i == 253) check_eq("sat_254", bus.errCount, 254);
    end
    check_eq("sat_255", bus.errCount, 255);
    check_eq("sat_noevt", bus.evtValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
